// File: rtl/imm_pipe_gen.sv
// Immediate generator: decodes the immediate from a 32-bit instruction word and
// passes it, with a sideband tag, through a 2-entry skid buffer (registered in_ready).
module imm_pipe_gen #(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b1,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [15:0]      illegal_cnt
);

  localparam logic [2:0] SEL_I = 3'd0, SEL_S = 3'd1, SEL_B = 3'd2,
                         SEL_U = 3'd3, SEL_J = 3'd4, SEL_Z = 3'd5;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  state_e      state_q, state_d;
  ent_t        out_q, out_d, skid_q, skid_d, new_ent;
  logic        rdy_q, rdy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  sel;
  logic        bad;
  logic [XLEN-1:0] imm;
  logic        acc, drn;

  // Type selection: opcode decode or the explicit selector.
  always_comb begin
    sel = in_imm_sel;
    bad = 1'b0;
    if (AUTO_DECODE) begin
      case (in_instr[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: sel = SEL_I;
        7'b0011011: begin sel = SEL_I; bad = (XLEN != 64); end
        7'b1110011: sel = in_instr[14] ? SEL_Z : SEL_I;
        7'b0100011: sel = SEL_S;
        7'b1100011: sel = SEL_B;
        7'b0110111, 7'b0010111: sel = SEL_U;
        7'b1101111: sel = SEL_J;
        default:    begin sel = SEL_I; bad = 1'b1; end
      endcase
    end else begin
      bad = (in_imm_sel > SEL_Z);
    end
  end

  // Start from a full sign fill and overlay the field bits.
  always_comb begin
    imm = {XLEN{in_instr[31]}};
    case (sel)
      SEL_I: imm[11:0] = in_instr[31:20];
      SEL_S: imm[11:0] = {in_instr[31:25], in_instr[11:7]};
      SEL_B: imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_U: imm[31:0] = {in_instr[31:12], 12'b0};
      SEL_J: imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      SEL_Z: begin imm = '0; imm[4:0] = in_instr[19:15]; end
      default: imm = '0;
    endcase
    if (bad) imm = '0;
  end

  assign new_ent   = '{imm: imm, tag: in_tag, ill: bad};
  assign out_valid = (state_q != EMPTY);
  assign acc       = in_valid & rdy_q;
  assign drn       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    if (drn && out_q.ill && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    case (state_q)
      EMPTY: if (acc) begin state_d = ONE; out_d = new_ent; end
      ONE: begin
        if (acc && drn)  out_d = new_ent;
        else if (acc)    begin state_d = FULL; skid_d = new_ent; end
        else if (drn)    state_d = EMPTY;
      end
      FULL: if (drn) begin state_d = ONE; out_d = skid_q; end
      default: state_d = EMPTY;
    endcase
    rdy_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = rdy_q;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.ill;
  assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_pipe_gen.md
IMM_PIPE_GEN -- requirements
Module: imm_pipe_gen

Interface
REQ-001 Parameter XLEN, default 32, meaning output immediate width; legal values 32 and 64 only.
REQ-002 Parameter AUTO_DECODE, default 1, meaning 1 = derive immediate type from opcode, 0 = use in_imm_sel.
REQ-003 Parameter TAG_W, default 5, meaning width of the sideband tag carried alongside each instruction.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 in_imm_sel  input  3  immediate type: I=0, S=1, B=2, U=3, J=4, Z=5; 6 and 7 illegal; ignored when AUTO_DECODE=1.
REQ-010 in_tag  input  TAG_W  sideband tag, passed through unchanged.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_imm  output  XLEN  generated immediate.
REQ-014 out_tag  output  TAG_W  tag of the instruction in out_imm.
REQ-015 out_illegal  output  1  type was illegal or opcode unrecognised; out_imm is 0 when set.
REQ-016 illegal_cnt  output  16  saturating count of illegal results delivered.

Function
REQ-017 Handshake: a transfer occurs on a cycle where valid and ready are both high, on either side. out_imm, out_tag and out_illegal hold stable while out_valid=1 and out_ready=0.
REQ-018 Storage: 2-entry skid buffer (output register + skid register). States: EMPTY (0 entries), ONE (output register valid), FULL (both valid).
REQ-019 in_ready is a registered signal: 1 in EMPTY and ONE, 0 in FULL; it does not depend combinationally on out_ready.
REQ-020 Transitions:
- EMPTY: accept -> ONE.
- ONE: accept without drain -> FULL; drain without accept -> EMPTY; accept and drain -> ONE, new entry in the output register.
- FULL: drain -> ONE, skid moves to the output register.
REQ-021 Latency: an instruction accepted in cycle N is presented with out_valid=1 in cycle N+1 if the output register is free; no bubbles under continuous flow with out_ready=1.
REQ-022 Results leave in acceptance order; the tag stays paired with its immediate.
REQ-023 Immediate computation happens before the storage registers; both entries hold final values.
REQ-024 Auto decode (opcode = instr[6:0]):
- I: 0010011, 0000011, 1100111, 0011011 (0011011 legal only when XLEN=64).
- I: 1110011 with instr[14]=0.
- Z: 1110011 with instr[14]=1.
- S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
- Any other opcode: illegal.
REQ-025 Bit fields:
- I = instr[31:20].
- S = {instr[31:25], instr[11:7]}.
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U = {instr[31:12], 12'b0}.
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Z = instr[19:15], zero-extended.
REQ-026 I, S, B, U and J are sign-extended from instr[31] to XLEN; U is therefore sign-extended from bit 31 when XLEN=64.
REQ-027 illegal_cnt increments by 1 on each output transfer with out_illegal=1 and holds at 16'hFFFF.

Reset
REQ-028 On rst=1 at a clock edge: state -> EMPTY, out_valid=0, in_ready=1, illegal_cnt=0, out_imm=0, out_tag=0, out_illegal=0. Any in-flight entries are discarded.
REQ-029 During the reset cycle, input handshakes are not accepted. Normal operation resumes on the first edge with rst=0.

Verification
REQ-030 XLEN=32, AUTO: in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
REQ-031 XLEN=64, AUTO: 0x12345037 then 0x80000037 back-to-back -> out_imm 0x0000000012345000, then 0xFFFFFFFF80000000, on consecutive cycles.
REQ-032 AUTO: 0x3401D073 (csrrwi x0,0x340,3) -> out_imm=3. AUTO=0, in_imm_sel=3'd7 -> out_illegal=1, out_imm=0.
REQ-033 Backpressure: tags 1, 2, 3 offered back-to-back with out_ready=0 -> tags 1 and 2 accepted, in_ready=0 from the cycle after the 2nd accept. Raise out_ready -> out_tag sequence is 1, 2, 3 with no loss or duplication.
REQ-034 0x0000007F delivered 65537 times -> illegal_cnt=0xFFFF and stays there.
REQ-035 FULL state, assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, illegal_cnt=0; the next accepted instruction emerges normally.
